// File: rtl/triangle_setup.sv
// Triangle setup stage: accepts one screen-space triangle, computes the
// doubled signed area, winding and 8.24 inverse area (serial restoring
// divide of 2^24), then offers the triangle to the rasterizer and waits
// for rasterizer_done before accepting the next one.
//
// Ports:
//   axi_aclk, axi_aresetn        clock, async active-low reset
//   in_valid / in_ready          upstream triangle handshake
//   in_v{1,2,3}{x,y}, in_color,  raw triangle (x 9b signed, y 8b signed,
//   in_z{1,2,3}                  RRRGGGBB color, 16b depth)
//   v*, color, z*                registered copy of the accepted triangle
//   inv_area, winding            floor(2^24/|area_x2|), sign of area_x2
//   triangle_valid / _ready      rasterizer handshake
//   rasterizer_done              rasterizer finished the issued triangle
//   degenerate                   one-cycle pulse on a dropped zero-area triangle
//   busy, tri_count, degen_count status and wrapping event counters
module triangle_setup #(
  parameter int unsigned DIV_BITS = 25
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_v1x,
  input  logic [7:0]  in_v1y,
  input  logic [8:0]  in_v2x,
  input  logic [7:0]  in_v2y,
  input  logic [8:0]  in_v3x,
  input  logic [7:0]  in_v3y,
  input  logic [7:0]  in_color,
  input  logic [15:0] in_z1,
  input  logic [15:0] in_z2,
  input  logic [15:0] in_z3,
  output logic [8:0]  v1x,
  output logic [7:0]  v1y,
  output logic [8:0]  v2x,
  output logic [7:0]  v2y,
  output logic [8:0]  v3x,
  output logic [7:0]  v3y,
  output logic [7:0]  color,
  output logic [15:0] z1,
  output logic [15:0] z2,
  output logic [15:0] z3,
  output logic [31:0] inv_area,
  output logic        winding,
  output logic        triangle_valid,
  input  logic        triangle_ready,
  input  logic        rasterizer_done,
  output logic        degenerate,
  output logic        busy,
  output logic [15:0] tri_count,
  output logic [15:0] degen_count
);

  localparam int unsigned AREA_W = 18;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned Q_W    = 32;
  localparam int unsigned ONE_POS = 24;  // dividend is 2^24

  typedef enum logic [2:0] {IDLE, AREA, DIV, ISSUE, WAIT_DONE} state_t;

  state_t              state, state_d;
  logic [AREA_W-1:0]   abs_area;
  logic [AREA_W-1:0]   rem;
  logic [Q_W-1:0]      quot;
  logic [CNT_W-1:0]    cnt;

  logic accept_c, area_c, degen_c, div_c, div_last_c, xfer_c;

  // Doubled signed area from the captured vertices
  logic signed [17:0] x1e, x2e, x3e, d23, d31, d12, p1, p2, p3;
  logic signed [19:0] area_s;
  logic [AREA_W-1:0]  area_abs_c;

  assign x1e = 18'($signed(v1x));
  assign x2e = 18'($signed(v2x));
  assign x3e = 18'($signed(v3x));
  assign d23 = 18'($signed(v2y)) - 18'($signed(v3y));
  assign d31 = 18'($signed(v3y)) - 18'($signed(v1y));
  assign d12 = 18'($signed(v1y)) - 18'($signed(v2y));
  assign p1  = x1e * d23;
  assign p2  = x2e * d31;
  assign p3  = x3e * d12;
  assign area_s     = 20'(p1) + 20'(p2) + 20'(p3);
  assign area_abs_c = AREA_W'(area_s[19] ? -area_s : area_s);

  // One restoring-division step; dividend bit is set only at position 24
  logic        dbit_c, qbit_c;
  logic [18:0] trial_c;
  logic [AREA_W-1:0] rem_nxt_c;
  logic [Q_W-1:0]    quot_nxt_c;

  assign dbit_c     = (cnt == CNT_W'(ONE_POS));
  assign trial_c    = {rem, dbit_c};
  assign qbit_c     = (trial_c >= {1'b0, abs_area});
  assign rem_nxt_c  = qbit_c ? AREA_W'(trial_c - {1'b0, abs_area}) : AREA_W'(trial_c);
  assign quot_nxt_c = Q_W'({quot, qbit_c});

  // State register
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d    = state;
    accept_c   = 1'b0;
    area_c     = 1'b0;
    degen_c    = 1'b0;
    div_c      = 1'b0;
    div_last_c = 1'b0;
    xfer_c     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_d  = AREA;
        end
      end
      AREA: begin
        area_c = 1'b1;
        if (area_s == '0) begin
          degen_c = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        div_c = 1'b1;
        if (cnt == '0) begin
          div_last_c = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (triangle_valid && triangle_ready) begin
          xfer_c  = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (rasterizer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      in_ready       <= 1'b0;
      busy           <= 1'b0;
      triangle_valid <= 1'b0;
      degenerate     <= 1'b0;
      winding        <= 1'b0;
      inv_area       <= '0;
      tri_count      <= '0;
      degen_count    <= '0;
      v1x <= '0; v1y <= '0; v2x <= '0; v2y <= '0; v3x <= '0; v3y <= '0;
      color <= '0; z1 <= '0; z2 <= '0; z3 <= '0;
      abs_area <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
    end else begin
      in_ready   <= (state_d == IDLE);
      busy       <= (state_d != IDLE);
      // Valid follows the ISSUE state by one cycle and drops right after transfer
      triangle_valid <= (state == ISSUE) && !xfer_c;
      degenerate <= degen_c;
      if (accept_c) begin
        v1x <= in_v1x; v1y <= in_v1y;
        v2x <= in_v2x; v2y <= in_v2y;
        v3x <= in_v3x; v3y <= in_v3y;
        color <= in_color;
        z1 <= in_z1; z2 <= in_z2; z3 <= in_z3;
      end
      if (area_c) begin
        winding  <= area_s[19];
        abs_area <= area_abs_c;
        rem      <= '0;
        quot     <= '0;
        cnt      <= CNT_W'(DIV_BITS - 1);
      end
      if (degen_c) degen_count <= degen_count + 16'd1;
      if (div_c) begin
        rem  <= rem_nxt_c;
        quot <= quot_nxt_c;
        cnt  <= cnt - CNT_W'(1);
      end
      if (div_last_c) inv_area <= quot_nxt_c;
      if (xfer_c) tri_count <= tri_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
// Randomized + directed bench for triangle_setup against an arithmetic
// reference model (signed area, integer 2^24 division, counters).
module tb_triangle_setup;

  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_v1x, in_v2x, in_v3x;
  logic [7:0]  in_v1y, in_v2y, in_v3y;
  logic [7:0]  in_color;
  logic [15:0] in_z1, in_z2, in_z3;
  logic [8:0]  v1x, v2x, v3x;
  logic [7:0]  v1y, v2y, v3y;
  logic [7:0]  color;
  logic [15:0] z1, z2, z3;
  logic [31:0] inv_area;
  logic        winding;
  logic        triangle_valid;
  logic        triangle_ready;
  logic        rasterizer_done;
  logic        degenerate;
  logic        busy;
  logic [15:0] tri_count;
  logic [15:0] degen_count;

  always #5 axi_aclk = ~axi_aclk;

  triangle_setup dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_v1x(in_v1x), .in_v1y(in_v1y), .in_v2x(in_v2x), .in_v2y(in_v2y),
    .in_v3x(in_v3x), .in_v3y(in_v3y), .in_color(in_color),
    .in_z1(in_z1), .in_z2(in_z2), .in_z3(in_z3),
    .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
    .color(color), .z1(z1), .z2(z2), .z3(z3),
    .inv_area(inv_area), .winding(winding),
    .triangle_valid(triangle_valid), .triangle_ready(triangle_ready),
    .rasterizer_done(rasterizer_done), .degenerate(degenerate),
    .busy(busy), .tri_count(tri_count), .degen_count(degen_count)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] e_geom, e_attr;
  logic [31:0] e_inv, last_inv;
  logic        e_wind, e_degen;
  logic [15:0] e_tri, e_deg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tri(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int col,
                         input int za, input int zb, input int zc);
    in_v1x = 9'(x1); in_v1y = 8'(y1);
    in_v2x = 9'(x2); in_v2y = 8'(y2);
    in_v3x = 9'(x3); in_v3y = 8'(y3);
    in_color = 8'(col);
    in_z1 = 16'(za); in_z2 = 16'(zb); in_z3 = 16'(zc);
  endtask

  // Reference: signed doubled area and truncated 2^24 / |area|
  function automatic void calc_expect();
    int x1 = int'($signed(in_v1x));
    int x2 = int'($signed(in_v2x));
    int x3 = int'($signed(in_v3x));
    int y1 = int'($signed(in_v1y));
    int y2 = int'($signed(in_v2y));
    int y3 = int'($signed(in_v3y));
    int a  = x1 * (y2 - y3) + x2 * (y3 - y1) + x3 * (y1 - y2);
    int aa = (a < 0) ? -a : a;
    e_degen = (a == 0);
    e_wind  = (a < 0);
    e_inv   = (a == 0) ? last_inv : 32'((1 << 24) / aa);
    e_geom  = 64'({in_v1x, in_v1y, in_v2x, in_v2y, in_v3x, in_v3y});
    e_attr  = 64'({in_color, in_z1, in_z2, in_z3});
  endfunction

  task automatic present();
    int t = 0;
    while (!in_ready && t < 100) begin
      @(negedge axi_aclk);
      t++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    @(negedge axi_aclk);
    in_valid = 1'b0;
  endtask

  // Called at the falling edge right after the accepting edge
  task automatic finish_tri(input int rdly);
    int lat;
    check("cap_geom", 64'({v1x, v1y, v2x, v2y, v3x, v3y}), e_geom);
    check("cap_attr", 64'({color, z1, z2, z3}), e_attr);
    check("busy_accept", 64'(busy), 64'(1));
    if (e_degen) begin
      @(negedge axi_aclk);
      e_deg++;
      check("degen_pulse", 64'(degenerate), 64'(1));
      check("degen_in_ready", 64'(in_ready), 64'(1));
      check("degen_count", 64'(degen_count), 64'(e_deg));
      check("degen_inv_hold", 64'(inv_area), 64'(last_inv));
      @(negedge axi_aclk);
      check("degen_clear", 64'(degenerate), 64'(0));
      check("degen_no_valid", 64'(triangle_valid), 64'(0));
    end else begin
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge axi_aclk);
        if (triangle_valid) begin
          lat = k;
          break;
        end
      end
      check("latency", 64'(lat), 64'(27));
      check("inv_area", 64'(inv_area), 64'(e_inv));
      check("winding", 64'(winding), 64'(e_wind));
      for (int i = 0; i < rdly; i++) begin
        @(negedge axi_aclk);
        check("hold_valid", 64'(triangle_valid), 64'(1));
        check("hold_inv", 64'(inv_area), 64'(e_inv));
        check("hold_geom", 64'({v1x, v1y, v2x, v2y, v3x, v3y}), e_geom);
      end
      triangle_ready = 1'b1;
      @(negedge axi_aclk);
      triangle_ready = 1'b0;
      e_tri++;
      check("xfer_valid_low", 64'(triangle_valid), 64'(0));
      check("tri_count", 64'(tri_count), 64'(e_tri));
      rasterizer_done = 1'b1;
      @(negedge axi_aclk);
      rasterizer_done = 1'b0;
      check("done_in_ready", 64'(in_ready), 64'(1));
      check("done_idle", 64'(busy), 64'(0));
      check("tri_count_once", 64'(tri_count), 64'(e_tri));
      last_inv = e_inv;
    end
  endtask

  task automatic run_tri(input int x1, input int y1, input int x2, input int y2,
                         input int x3, input int y3, input int col,
                         input int za, input int zb, input int zc, input int rdly);
    set_tri(x1, y1, x2, y2, x3, y3, col, za, zb, zc);
    calc_expect();
    present();
    finish_tri(rdly);
  endtask

  task automatic reset_model();
    e_tri = '0;
    e_deg = '0;
    last_inv = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    axi_aresetn = 1'b0;
    in_valid = 1'b0;
    triangle_ready = 1'b0;
    rasterizer_done = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_model();
    repeat (3) @(negedge axi_aclk);

    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(triangle_valid), 64'(0));
    check("rst_degen", 64'(degenerate), 64'(0));
    check("rst_winding", 64'(winding), 64'(0));
    check("rst_inv", 64'(inv_area), 64'(0));
    check("rst_counts", 64'({tri_count, degen_count}), 64'(0));
    check("rst_geom", 64'({v1x, v1y, v2x, v2y, v3x, v3y, color}), 64'(0));
    axi_aresetn = 1'b1;
    #1;
    check("rel_in_ready_low", 64'(in_ready), 64'(0));
    @(negedge axi_aclk);
    check("rel_in_ready_high", 64'(in_ready), 64'(1));

    // Directed geometry
    run_tri(100, -50, 200, 50, 100, 50, 'hE0, 50, 50, 50, 0);
    run_tri(200, 50, 150, 100, 250, 100, 'h1C, 100, 200, 300, 10);
    run_tri(0, 0, 10, 10, 20, 20, 'h03, 1, 2, 3, 0);
    run_tri(0, 0, 1, 0, 0, 1, 'hFF, 7, 8, 9, 0);
    run_tri(-256, -128, 255, -128, -256, 127, 'h55, 65535, 0, 32768, 1);

    // done held high across issue with in_valid held high
    set_tri(10, 10, 100, 10, 10, 100, 'h12, 11, 22, 33);
    calc_expect();
    rasterizer_done = 1'b1;
    triangle_ready = 1'b1;
    present_hold: begin
      int t = 0;
      while (!in_ready && t < 100) begin
        @(negedge axi_aclk);
        t++;
      end
    end
    in_valid = 1'b1;
    @(negedge axi_aclk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge axi_aclk);
      if (k == 5) set_tri(-20, 30, 40, -60, 90, 90, 'hA5, 4, 5, 6);
      if (k == 10) check("busy_ignore_in", 64'({v1x, v1y, v2x, v2y, v3x, v3y}), e_geom);
      if (k == 26) check("dh_valid_early", 64'(triangle_valid), 64'(0));
      if (k == 27) begin
        check("dh_valid", 64'(triangle_valid), 64'(1));
        check("dh_inv", 64'(inv_area), 64'(e_inv));
      end
      if (k == 28) begin
        e_tri++;
        check("dh_xfer", 64'({triangle_valid, busy}), 64'(2'b01));
        check("dh_tri_count", 64'(tri_count), 64'(e_tri));
      end
      if (k == 29) check("dh_idle", 64'({in_ready, busy}), 64'(2'b10));
      if (k == 30) check("dh_reaccept", 64'({in_ready, busy}), 64'(2'b01));
    end
    in_valid = 1'b0;
    rasterizer_done = 1'b0;
    triangle_ready = 1'b0;
    last_inv = e_inv;
    calc_expect();
    finish_tri(1);

    // Reset mid-DIV
    set_tri(5, 5, 60, 5, 5, 70, 'h0F, 9, 9, 9);
    calc_expect();
    present();
    repeat (10) @(negedge axi_aclk);
    axi_aresetn = 1'b0;
    #1;
    check("div_rst_flags", 64'({in_ready, busy, triangle_valid, winding, degenerate}), 64'(0));
    check("div_rst_counts", 64'({tri_count, degen_count}), 64'(0));
    check("div_rst_inv", 64'(inv_area), 64'(0));
    check("div_rst_geom", 64'({v1x, v1y, v2x, v2y, v3x, v3y}), 64'(0));
    check("div_rst_attr", 64'({color, z1, z2, z3}), 64'(0));
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    reset_model();
    run_tri(-100, -100, 100, -100, 0, 100, 'hC3, 1000, 2000, 3000, 2);

    // Reset mid-ISSUE
    set_tri(30, 0, 0, 40, 0, 0, 'h21, 1, 1, 1);
    calc_expect();
    present();
    for (int k = 0; k < 40 && !triangle_valid; k++) @(negedge axi_aclk);
    check("issue_valid_before_rst", 64'(triangle_valid), 64'(1));
    axi_aresetn = 1'b0;
    #1;
    check("issue_rst_valid", 64'(triangle_valid), 64'(0));
    check("issue_rst_counts", 64'({tri_count, degen_count}), 64'(0));
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    reset_model();

    // Randomized triangles, some forced collinear
    for (int i = 0; i < 40; i++) begin
      int x1, x2, x3, y1, y2, y3;
      x1 = int'($urandom_range(0, 511)) - 256;
      x2 = int'($urandom_range(0, 511)) - 256;
      x3 = int'($urandom_range(0, 511)) - 256;
      y1 = int'($urandom_range(0, 255)) - 128;
      y2 = int'($urandom_range(0, 255)) - 128;
      y3 = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) begin
        y2 = y1;
        y3 = y1;
      end
      run_tri(x1, y1, x2, y2, x3, y3, int'($urandom_range(0, 255)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
